uart_rx_oracle: RTL and testbench
=================================

UART_RX_ORACLE -- requirements
Module: uart_rx_oracle

Interface
REQ-001 Parameter BIT_LEN, default 7, sets the number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 3, sets clock cycles per bit period; it SHALL be odd and >= 3.
REQ-003 Port clk, input, 1, is the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rstn, input, 1, is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port rx_channel_in, input, 1, is the serial line; it is synchronous to clk, idles high and has no synchronizer.
REQ-006 Port rx_data_out, output, BIT_LEN, holds the last received data word.
REQ-007 Port rx_valid, output, 1, is high while the last frame was error-free.
REQ-008 Port rx_parity_err, output, 1, is high while the last frame failed the parity check.
REQ-009 Port rx_frame_err, output, 1, is high while the last frame's stop bit voted 0.
REQ-010 Port rx_busy, output, 1, is high whenever the state is not IDLE.

Function
REQ-011 Frame format SHALL be: start bit 0, then BIT_LEN data bits LSB first, then an even-parity bit, then stop bit 1.
REQ-012 Bit value SHALL be the majority vote of the CLKS_PER_BIT samples in its period: the bit is 1 when the count of ones exceeds CLKS_PER_BIT/2.
REQ-013 The state machine SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-014 IDLE: a sample of rx_channel_in == 0 SHALL move the state to START, and that cycle SHALL count as start-bit sample 1.
REQ-015 START period end:
- vote 1 (false start): return to IDLE and leave all result outputs unchanged;
- vote 0: move to DATA.
REQ-016 DATA SHALL last BIT_LEN periods, shift each voted bit in LSB first, then move to PARITY.
REQ-017 PARITY SHALL last one period and store the voted parity bit, then move to STOP.
REQ-018 STOP period end: on the clock edge of the last stop sample, rx_data_out SHALL load the shifted word and the outputs SHALL update as follows:
- rx_parity_err = (XOR of data and parity bit) != 0;
- rx_frame_err = (stop vote == 0);
- rx_valid = !rx_parity_err && !rx_frame_err;
- the state returns to IDLE.
REQ-019 Latency from start-bit sample 1 to the result update SHALL be (BIT_LEN+3)*CLKS_PER_BIT cycles, which is 30 at the default parameters.
REQ-020 rx_data_out SHALL be loaded even on error.
REQ-021 Result outputs SHALL hold until the next accepted start bit (start vote 0), at which point rx_valid, rx_parity_err and rx_frame_err SHALL clear to 0.
REQ-022 A line low in IDLE on the cycle after STOP SHALL be accepted as a new start, so back-to-back frames need no idle gap.
REQ-023 Per-period sample counter and ones counter SHALL wrap to 0 at each period boundary; the data-bit index SHALL range 0..BIT_LEN-1.

Reset
REQ-024 rstn low SHALL immediately force:
- state IDLE and all counters 0;
- rx_data_out 0, rx_valid 0, rx_parity_err 0, rx_frame_err 0, rx_busy 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no result update.
REQ-026 After rstn deasserts, the block SHALL wait in IDLE for a low sample.

Structure
REQ-027 The state encoding and frame constants (parity = even, stop level = 1, idle level = 1) SHALL live in shared package uart_pkg, which the UART transmitter also uses.
REQ-028 Sub-module uart_bit_sampler SHALL hold the per-period sample counter, the ones counter and the majority vote.
- It SHALL output a period-done strobe and the voted bit.
- The FSM and shift register SHALL stay in uart_rx_oracle.

Verification (BIT_LEN=7, CLKS_PER_BIT=3)
REQ-029 Line high for 20 cycles after reset -> rx_busy 0, rx_valid 0 and rx_data_out 0 throughout.
REQ-030 Clean frame for 7'h53, parity bit 0 -> exactly 30 cycles after the start, rx_data_out=7'h53, rx_valid=1 and both errors 0.
REQ-031 Frame 7'h53 with one sample of data bit 2 flipped -> rx_data_out=7'h53 and rx_valid=1, since the majority vote masks the flip.
REQ-032 Frame 7'h53 with the parity bit sent as 1 -> rx_parity_err=1, rx_valid=0 and rx_data_out=7'h53.
REQ-033 Frame 7'h2A with the stop bit sent as 0 -> rx_frame_err=1 and rx_valid=0; a line low for 1 cycle then high -> false start, rx_busy low again after 3 cycles and outputs unchanged.
REQ-034 rstn pulsed low at cycle 12 of a frame -> all outputs 0 at once; the next clean frame 7'h11 is then received with rx_valid=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame levels and the majority-vote threshold.
// Purely declarative: no latency and no flow control.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Even parity: data bits plus parity bit must XOR to this value.
    localparam logic PARITY_ODD = 1'b0;
    localparam logic STOP_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // A bit votes 1 when its count of high samples is strictly above this.
    function automatic int vote_threshold(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Per-bit-period sample counter and ones counter with a majority vote over CLKS_PER_BIT samples.
// Latency: done/bit are combinational on the last sample of a period; no backpressure, samples whenever enabled.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_en,
    input  logic i_sample,
    output logic o_done,
    output logic o_bit
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] LAST_V   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(vote_threshold(CLKS_PER_BIT));

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ones;
    logic [CNT_W-1:0] w_ones_total;

    // The vote includes the sample arriving on the final cycle of the period.
    assign w_ones_total = r_ones + {{(CNT_W-1){1'b0}}, i_sample};
    assign o_done       = i_en && (r_cnt == LAST_V);
    assign o_bit        = (w_ones_total > THRESH_V);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_ones <= '0;
        end else if (i_en) begin
            if (o_done) begin
                r_cnt  <= '0;
                r_ones <= '0;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_ones <= w_ones_total;
            end
        end
    end

endmodule

// File: rtl/uart_rx_oracle.sv
// UART receiver: start, BIT_LEN data bits LSB first, even parity, stop; majority-voted bits.
// Latency: results update (BIT_LEN+3)*CLKS_PER_BIT cycles after start-bit sample 1; no backpressure, results hold until next accepted start.
module uart_rx_oracle
    import uart_pkg::*;
#(
    parameter int BIT_LEN      = 7,
    parameter int CLKS_PER_BIT = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               rx_channel_in,
    output logic [BIT_LEN-1:0] rx_data_out,
    output logic               rx_valid,
    output logic               rx_parity_err,
    output logic               rx_frame_err,
    output logic               rx_busy
);

    localparam int IDX_W = (BIT_LEN > 1) ? $clog2(BIT_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BIT_LEN - 1);

    uart_state_t r_state;
    uart_state_t w_state_nxt;

    logic [BIT_LEN-1:0] r_shift;
    logic [IDX_W-1:0]   r_bit_idx;
    logic               r_parity;
    logic [BIT_LEN-1:0] r_data;
    logic               r_valid;
    logic               r_perr;
    logic               r_ferr;

    logic w_sample_en;
    logic w_done;
    logic w_bit;
    logic w_accept;
    logic w_shift;
    logic w_par_ld;
    logic w_finish;
    logic w_perr;

    // In IDLE only a low line is counted, so that cycle becomes start sample 1.
    assign w_sample_en = (r_state != ST_IDLE) || (rx_channel_in != IDLE_LEVEL);

    uart_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk      (clk),
        .rstn     (rstn),
        .i_en     (w_sample_en),
        .i_sample (rx_channel_in),
        .o_done   (w_done),
        .o_bit    (w_bit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_par_ld    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_channel_in != IDLE_LEVEL) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_done) begin
                    if (w_bit) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                        w_accept    = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_done) begin
                    w_shift = 1'b1;
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_nxt = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (w_done) begin
                    w_par_ld    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_done) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_perr = (^r_shift) ^ r_parity ^ PARITY_ODD;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_valid   <= 1'b0;
                r_perr    <= 1'b0;
                r_ferr    <= 1'b0;
                r_bit_idx <= '0;
            end
            if (w_shift) begin
                r_shift   <= {w_bit, r_shift[BIT_LEN-1:1]};
                r_bit_idx <= (r_bit_idx == IDX_LAST) ? '0 : r_bit_idx + IDX_W'(1);
            end
            if (w_par_ld) begin
                r_parity <= w_bit;
            end
            // The word is loaded even when the frame is bad.
            if (w_finish) begin
                r_data  <= r_shift;
                r_perr  <= w_perr;
                r_ferr  <= (w_bit != STOP_LEVEL);
                r_valid <= !w_perr && (w_bit == STOP_LEVEL);
            end
        end
    end

    assign rx_data_out   = r_data;
    assign rx_valid      = r_valid;
    assign rx_parity_err = r_perr;
    assign rx_frame_err  = r_ferr;
    assign rx_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oracle.sv
// Bench for uart_rx_oracle: frame-level stimulus tables expanded into per-cycle line values and
// per-cycle expected outputs, compared every cycle, plus literal pins for the directed scenarios.
module tb_uart_rx_oracle;

    localparam int BL   = 7;
    localparam int CPB  = 3;
    localparam int NP   = BL + 3;
    localparam int NS   = NP * CPB;
    localparam int MAXC = 4000;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rx;
    logic [BL-1:0] data_o;
    logic          valid_o;
    logic          perr_o;
    logic          ferr_o;
    logic          busy_o;

    uart_rx_oracle #(
        .BIT_LEN      (BL),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .rx_channel_in (rx),
        .rx_data_out   (data_o),
        .rx_valid      (valid_o),
        .rx_parity_err (perr_o),
        .rx_frame_err  (ferr_o),
        .rx_busy       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [BL-1:0] d;
        logic          v;
        logic          pe;
        logic          fe;
        logic          busy;
    } pin_t;

    logic          line_arr [MAXC];
    logic          rst_arr  [MAXC];
    logic [BL-1:0] e_data   [MAXC];
    logic          e_valid  [MAXC];
    logic          e_pe     [MAXC];
    logic          e_fe     [MAXC];
    logic          e_busy   [MAXC];
    pin_t          pins[$];

    int            ncyc = 0;
    logic [BL-1:0] h_data;
    logic          h_valid;
    logic          h_pe;
    logic          h_fe;

    int checks = 0;
    int errors = 0;

    // e_*[c] is what the outputs must show during cycle c, i.e. after the line value of cycle c-1.
    task automatic put_exp(input int idx, input logic busy);
        e_data[idx]  = h_data;
        e_valid[idx] = h_valid;
        e_pe[idx]    = h_pe;
        e_fe[idx]    = h_fe;
        e_busy[idx]  = busy;
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            line_arr[ncyc] = 1'b1;
            rst_arr[ncyc]  = 1'b1;
            put_exp(ncyc + 1, 1'b0);
            ncyc++;
        end
    endtask

    task automatic add_reset(input int n);
        h_data  = '0;
        h_valid = 1'b0;
        h_pe    = 1'b0;
        h_fe    = 1'b0;
        for (int i = 0; i < n; i++) begin
            line_arr[ncyc] = 1'b1;
            rst_arr[ncyc]  = 1'b0;
            put_exp(ncyc, 1'b0);
            put_exp(ncyc + 1, 1'b0);
            ncyc++;
        end
    endtask

    task automatic add_false_start();
        for (int i = 0; i < CPB; i++) begin
            line_arr[ncyc] = (i != 0);
            rst_arr[ncyc]  = 1'b1;
            put_exp(ncyc + 1, i < CPB - 1);
            ncyc++;
        end
    endtask

    // Start sample 1 must stay low and the start period must vote 0 (callers keep flips there to one).
    task automatic add_frame(input logic [BL-1:0] d, input logic par_bad, input logic stop_bit,
                             input logic [NS-1:0] flip, input int abort_at);
        logic          b [NP];
        logic          s [NS];
        logic          v [NP];
        logic [BL-1:0] wd;
        int            ones;
        b[0] = 1'b0;
        for (int i = 0; i < BL; i++) b[i+1] = d[i];
        b[BL+1] = (^d) ^ par_bad;
        b[BL+2] = stop_bit;
        for (int i = 0; i < NS; i++) s[i] = b[i / CPB] ^ flip[i];
        for (int k = 0; k < NP; k++) begin
            ones = 0;
            for (int j = 0; j < CPB; j++) ones += int'(s[k*CPB + j]);
            v[k] = (ones > CPB / 2);
        end
        for (int i = 0; i < BL; i++) wd[i] = v[i+1];
        for (int i = 0; i < NS && i < abort_at; i++) begin
            line_arr[ncyc] = s[i];
            rst_arr[ncyc]  = 1'b1;
            if (i == CPB - 1) begin
                h_valid = 1'b0;
                h_pe    = 1'b0;
                h_fe    = 1'b0;
            end
            if (i == NS - 1) begin
                h_data  = wd;
                h_pe    = (^wd) ^ v[BL+1];
                h_fe    = !v[BL+2];
                h_valid = !h_pe && !h_fe;
            end
            put_exp(ncyc + 1, i < NS - 1);
            ncyc++;
        end
    endtask

    function automatic logic [NS-1:0] rand_flips();
        logic [NS-1:0] m;
        int            r;
        int            j;
        m = '0;
        for (int k = 0; k < NP; k++) begin
            r = int'($urandom_range(0, 9));
            j = int'($urandom_range(0, CPB - 1));
            if (k == 0) begin
                if (r < 3) m[int'($urandom_range(1, CPB - 1))] = 1'b1;
            end else if (r < 2) begin
                m[k*CPB + j] = 1'b1;
            end else if (r == 2) begin
                m[k*CPB + j] = 1'b1;
                m[k*CPB + ((j + 1) % CPB)] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic pin(input int c, input logic [BL-1:0] d, input logic v, input logic pe,
                       input logic fe, input logic busy);
        pin_t p;
        p.cyc  = c;
        p.d    = d;
        p.v    = v;
        p.pe   = pe;
        p.fe   = fe;
        p.busy = busy;
        pins.push_back(p);
    endtask

    task automatic cmp(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cyc=%0d %s got=%0h expected=%0h", c, name, got, exp);
        end
    endtask

    task automatic check_cycle(input int c);
        cmp("data",  c, 32'(data_o),  32'(e_data[c]));
        cmp("valid", c, 32'(valid_o), 32'(e_valid[c]));
        cmp("perr",  c, 32'(perr_o),  32'(e_pe[c]));
        cmp("ferr",  c, 32'(ferr_o),  32'(e_fe[c]));
        cmp("busy",  c, 32'(busy_o),  32'(e_busy[c]));
        foreach (pins[i]) begin
            if (pins[i].cyc == c) begin
                cmp("pin_data",  c, 32'(data_o),  32'(pins[i].d));
                cmp("pin_valid", c, 32'(valid_o), 32'(pins[i].v));
                cmp("pin_perr",  c, 32'(perr_o),  32'(pins[i].pe));
                cmp("pin_ferr",  c, 32'(ferr_o),  32'(pins[i].fe));
                cmp("pin_busy",  c, 32'(busy_o),  32'(pins[i].busy));
            end
        end
    endtask

    initial begin
        int            c0;
        int            r;
        logic [NS-1:0] fl;
        rstn = 1'b0;
        rx   = 1'b1;

        add_reset(3);
        pin(1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add_idle(20);
        pin(22, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        c0 = ncyc;
        add_frame(7'h53, 1'b0, 1'b1, '0, NS);
        pin(c0 + 29, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        pin(c0 + 30, 7'h53, 1'b1, 1'b0, 1'b0, 1'b0);
        add_idle(5);

        // One sample of data bit 2 (period 3, middle sample) inverted.
        c0 = ncyc;
        fl = '0;
        fl[3*CPB + 1] = 1'b1;
        add_frame(7'h53, 1'b0, 1'b1, fl, NS);
        pin(c0 + 30, 7'h53, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back with no idle gap, bad parity.
        c0 = ncyc;
        add_frame(7'h53, 1'b1, 1'b1, '0, NS);
        pin(c0 + 2, 7'h53, 1'b1, 1'b0, 1'b0, 1'b1);
        pin(c0 + 3, 7'h53, 1'b0, 1'b0, 1'b0, 1'b1);
        pin(c0 + 30, 7'h53, 1'b0, 1'b1, 1'b0, 1'b0);
        add_idle(4);

        c0 = ncyc;
        add_frame(7'h2A, 1'b0, 1'b0, '0, NS);
        pin(c0 + 30, 7'h2A, 1'b0, 1'b0, 1'b1, 1'b0);
        add_idle(3);

        c0 = ncyc;
        add_false_start();
        pin(c0 + 1, 7'h2A, 1'b0, 1'b0, 1'b1, 1'b1);
        pin(c0 + 3, 7'h2A, 1'b0, 1'b0, 1'b1, 1'b0);
        add_idle(3);

        c0 = ncyc;
        add_frame(7'h11, 1'b0, 1'b1, '0, 12);
        add_reset(2);
        pin(c0 + 12, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add_idle(5);
        c0 = ncyc;
        add_frame(7'h11, 1'b0, 1'b1, '0, NS);
        pin(c0 + 30, 7'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        add_idle(2);

        for (int it = 0; it < 45; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                add_false_start();
            end else if (r == 1) begin
                add_frame(BL'($urandom), 1'b0, 1'b1, rand_flips(), int'($urandom_range(1, NS - 1)));
                add_reset(int'($urandom_range(1, 3)));
            end else begin
                add_frame(BL'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0),
                          rand_flips(), NS);
            end
            add_idle(int'($urandom_range(0, 3)));
        end
        add_idle(3);

        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            rstn = rst_arr[c];
            rx   = line_arr[c];
            @(negedge clk);
            check_cycle(c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
